// File: rtl/aln3_pkg.sv
// aln3_pkg: state codes, consumption masks and pointer address packing shared by
// the 3-sequence alignment fill and traceback blocks.
package aln3_pkg;
   localparam int ALN_IDX_W = 8;
   localparam int ALN_PTR_W = 3;
   typedef enum logic [2:0] {ST_M, ST_IXY, ST_IYZ, ST_IXZ, ST_IX, ST_IY, ST_IZ, ST_STOP} aln_st_t;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} tb_fsm_t;
   function automatic logic [2:0] st_mask(input logic [2:0] s);
      case (s)
         ST_M:    return 3'b111;
         ST_IXY:  return 3'b110;
         ST_IYZ:  return 3'b011;
         ST_IXZ:  return 3'b101;
         ST_IX:   return 3'b100;
         ST_IY:   return 3'b010;
         ST_IZ:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction
   function automatic logic [3*ALN_IDX_W+ALN_PTR_W-1:0] pack_addr(input logic [ALN_IDX_W-1:0] i, j, k,
                                                               input logic [ALN_PTR_W-1:0] s);
      return {i, j, k, s};
   endfunction
endpackage

// File: rtl/tb_col_skid.sv
// tb_col_skid: single-entry registered output stage for the column stream.
module tb_col_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid <= 1'b0;
         q <= '0;
      end else begin
         valid <= load | (valid & ~ready);
         if (load) q <= d;
      end
endmodule

// File: rtl/traceback_3d.sv
// traceback_3d: walks the predecessor-pointer memory from (LA,LB,LC) back to the origin,
// streaming one alignment column per step. TB_COL_COUNT_EN adds col_count and an overrun check.
module traceback_3d import aln3_pkg::*; #(
   parameter int IDX_W = ALN_IDX_W,
   parameter int PTR_W = ALN_PTR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [IDX_W-1:0]         len_a,
   input  logic [IDX_W-1:0]         len_b,
   input  logic [IDX_W-1:0]         len_c,
   input  logic [PTR_W-1:0]         start_state,
   output logic                     ptr_rd_en,
   output logic [3*IDX_W+PTR_W-1:0] ptr_addr,
   input  logic [PTR_W-1:0]         ptr_rd_data,
   output logic                     col_valid,
   input  logic                     col_ready,
   output logic [2:0]               col_mask,
   output logic [IDX_W-1:0]         col_i,
   output logic [IDX_W-1:0]         col_j,
   output logic [IDX_W-1:0]         col_k,
   output logic                     busy,
   output logic                     done,
   output logic                     err
`ifdef TB_COL_COUNT_EN
   ,
   output logic [IDX_W+1:0]         col_count
`endif
);
   tb_fsm_t state, nxt;
   logic [IDX_W-1:0] i, j, k, ni, nj, nk;
   logic [PTR_W-1:0] s, ns;
   logic [2:0] m;
   logic hs, org0, bad0, org1, bad1, over, set_err;
   // a cell is a dead end if its state is STOP or it would step below index 0
   function automatic logic illegal(input logic [IDX_W-1:0] a, b, c, input logic [PTR_W-1:0] st);
      logic [2:0] sm;
      sm = st_mask(3'(st));
      return (3'(st) == ST_STOP) | (a == '0 & sm[2]) | (b == '0 & sm[1]) | (c == '0 & sm[0]);
   endfunction
`ifdef TB_COL_COUNT_EN
   logic [IDX_W+1:0] cnt, sum;
   assign over = (cnt + (IDX_W+2)'(1)) > sum;
   assign col_count = cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         sum <= '0;
      end else if (state == IDLE && start) begin
         cnt <= '0;
         sum <= (IDX_W+2)'(len_a) + (IDX_W+2)'(len_b) + (IDX_W+2)'(len_c);
      end else if (hs) cnt <= cnt + (IDX_W+2)'(1);
`else
   assign over = 1'b0;
`endif
   always_comb begin
      m = st_mask(3'(s));
      ni = i - IDX_W'(m[2]);
      nj = j - IDX_W'(m[1]);
      nk = k - IDX_W'(m[0]);
      hs = col_valid & col_ready;
      org0 = ~|{len_a, len_b, len_c};
      bad0 = illegal(len_a, len_b, len_c, start_state);
      org1 = ~|{ni, nj, nk};
      bad1 = illegal(ni, nj, nk, ns) | over;
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = (org0 | bad0) ? DONE : FETCH;
         FETCH:   nxt = WAIT;
         WAIT:    nxt = EMIT;
         EMIT:    if (hs) nxt = (org1 | bad1) ? DONE : FETCH;
         default: nxt = IDLE;
      endcase
      set_err = (state == IDLE && start && !org0 && bad0) || (state == EMIT && hs && !org1 && bad1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         i <= '0;
         j <= '0;
         k <= '0;
         s <= '0;
         ns <= '0;
         err <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            i <= len_a;
            j <= len_b;
            k <= len_c;
            s <= start_state;
            err <= 1'b0;
         end
         if (state == WAIT) ns <= ptr_rd_data;
         if (state == EMIT && hs) begin
            i <= ni;
            j <= nj;
            k <= nk;
            s <= ns;
         end
         if (set_err) err <= 1'b1;
      end
   assign ptr_rd_en = state == FETCH;
   assign ptr_addr = {i, j, k, s};
   assign busy = state != IDLE;
   assign done = state == DONE;
   tb_col_skid #(.W(3 + 3*IDX_W)) u_skid (
      .clk(clk),
      .rst(rst),
      .load(state == WAIT),
      .d({m, i, j, k}),
      .ready(col_ready),
      .valid(col_valid),
      .q({col_mask, col_i, col_j, col_k})
   );
endmodule

// File: tb/tb_traceback_3d.sv
// tb_traceback_3d: directed bench for traceback_3d with a path-walking reference model.
// Build with TB_COL_COUNT_EN to also check col_count.
module tb_traceback_3d;
   localparam int IW = 8, PW = 3, AW = 3*IW+PW;
   logic clk = 0, rst = 1, start = 0, col_ready = 0;
   logic [IW-1:0] len_a = 0, len_b = 0, len_c = 0;
   logic [PW-1:0] start_state = 0, ptr_rd_data = 0;
   logic ptr_rd_en, col_valid, busy, done, err;
   logic [AW-1:0] ptr_addr;
   logic [2:0] col_mask;
   logic [IW-1:0] col_i, col_j, col_k;
`ifdef TB_COL_COUNT_EN
   logic [IW+1:0] col_count;
`endif
   int total = 0, bad = 0, reads = 0;
   logic [2:0] mtab [8] = '{3'b111, 3'b110, 3'b011, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};
   logic [2:0] mem [int];
   logic [2:0] dflt = 0;
   logic [26:0] exp_q [$];
   logic exp_err = 0;

   always #5 clk = ~clk;

   traceback_3d dut (
      .clk(clk), .rst(rst), .start(start),
      .len_a(len_a), .len_b(len_b), .len_c(len_c), .start_state(start_state),
      .ptr_rd_en(ptr_rd_en), .ptr_addr(ptr_addr), .ptr_rd_data(ptr_rd_data),
      .col_valid(col_valid), .col_ready(col_ready), .col_mask(col_mask),
      .col_i(col_i), .col_j(col_j), .col_k(col_k),
      .busy(busy), .done(done), .err(err)
`ifdef TB_COL_COUNT_EN
      , .col_count(col_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int addr(input int i, j, k, s);
      return (i << 19) | (j << 11) | (k << 3) | s;
   endfunction

   function automatic logic [2:0] lookup(input logic [AW-1:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : dflt;
   endfunction

   function automatic bit bad_cell(input int i, j, k, s);
      logic [2:0] mk;
      mk = mtab[s];
      return s == 7 || (i == 0 && mk[2]) || (j == 0 && mk[1]) || (k == 0 && mk[0]);
   endfunction

   // pointer memory: data one cycle after the read strobe, STOP otherwise
   always @(posedge clk) ptr_rd_data <= ptr_rd_en ? lookup(ptr_addr) : 3'd7;

   // reference: follow the pointers from the end cell and list every column in order
   task automatic build(input int la, lb, lc, s0);
      int i, j, k, s, nsv;
      logic [2:0] mk;
      i = la; j = lb; k = lc; s = s0;
      exp_q.delete();
      exp_err = 0;
      if (i + j + k == 0) return;
      if (bad_cell(i, j, k, s)) begin exp_err = 1; return; end
      for (int n = 0; n < 1000; n++) begin
         mk = mtab[s];
         nsv = int'(lookup(AW'(addr(i, j, k, s))));
         exp_q.push_back({mk, 8'(i), 8'(j), 8'(k)});
         i -= int'(mk[2]); j -= int'(mk[1]); k -= int'(mk[0]);
         s = nsv;
         if (i + j + k == 0) return;
         if (bad_cell(i, j, k, s)) begin exp_err = 1; return; end
      end
   endtask

   always @(negedge clk) begin
      if (ptr_rd_en) reads++;
      if (col_valid) begin
         chk("rd_in_emit", 32'(ptr_rd_en), 0);
         if (exp_q.size() == 0) chk("extra_col", 32'(col_valid), 0);
         else begin
            chk("col", 32'({col_mask, col_i, col_j, col_k}), 32'(exp_q[0]));
            if (col_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic run(input int la, lb, lc, s0, nlit, elit, bp);
      int n, lat, ncol;
      build(la, lb, lc, s0);
      ncol = exp_q.size();
      chk("model_cols", 32'(ncol), 32'(nlit));
      chk("model_err", 32'(exp_err), 32'(elit));
      reads = 0;
      col_ready = !bp;
      len_a = IW'(la); len_b = IW'(lb); len_c = IW'(lc); start_state = PW'(s0);
      start = 1;
      @(posedge clk); #1 start = 0;
      lat = 1;
      while (!col_valid && !done && lat < 20) begin @(posedge clk); #1 lat++; end
      if (ncol > 0) chk("latency", 32'(lat), 3);
      else chk("early_done", 32'(lat), 1);
      if (bp) begin
         start = 1; len_a = 0; len_b = 0; len_c = 0;
         repeat (5) begin @(posedge clk); #1 start = 0; end
         chk("bp_hold", 32'(col_valid), 1);
         col_ready = 1;
      end
      n = 0;
      while (!done && n < 500) begin @(posedge clk); #1 n++; end
      chk("done_seen", 32'(done), 1);
      chk("err", 32'(err), 32'(exp_err));
      chk("cols_left", 32'(exp_q.size()), 0);
      chk("reads", 32'(reads), 32'(ncol));
`ifdef TB_COL_COUNT_EN
      chk("col_count", 32'(col_count), 32'(ncol));
`endif
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 0);
      chk("idle", 32'(busy), 0);
      chk("err_sticky", 32'(err), 32'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(col_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rd", 32'(ptr_rd_en), 0);
      chk("rst_addr", 32'(ptr_addr), 0);
      rst = 0;
      @(posedge clk); #1;
      dflt = 3'd0;
      run(3, 3, 3, 0, 3, 0, 0);
      mem.delete(); dflt = 3'd7;
      mem[addr(2, 1, 1, 0)] = 3'd4;
      mem[addr(1, 0, 0, 4)] = 3'd4;
      run(2, 1, 1, 0, 2, 0, 0);
      mem.delete();
      mem[addr(1, 2, 1, 2)] = 3'd1;
      mem[addr(1, 1, 1, 3)] = 3'd5;
      run(1, 2, 1, 2, 2, 0, 0);
      run(1, 1, 1, 3, 2, 0, 0);
      run(0, 0, 0, 0, 0, 0, 0);
      mem.delete();
      mem[addr(2, 2, 0, 1)] = 3'd6;
      run(2, 2, 0, 1, 1, 1, 0);
      mem.delete(); dflt = 3'd0;
      run(3, 3, 3, 0, 3, 0, 1);
      run(0, 1, 1, 0, 0, 1, 0);
      run(1, 1, 1, 7, 0, 1, 0);
      len_a = 3; len_b = 3; len_c = 3; start_state = 0;
      start = 1;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1;
      chk("mid_busy", 32'(busy), 1);
      rst = 1;
      #1;
      chk("ar_valid", 32'(col_valid), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_done", 32'(done), 0);
      chk("ar_rd", 32'(ptr_rd_en), 0);
      chk("ar_addr", 32'(ptr_addr), 0);
      chk("ar_col", 32'({col_mask, col_i, col_j, col_k}), 0);
`ifdef TB_COL_COUNT_EN
      chk("ar_count", 32'(col_count), 0);
`endif
      @(posedge clk); #1 rst = 0;
      @(posedge clk); #1;
      chk("ar_no_done", 32'(done), 0);
      run(3, 3, 3, 0, 3, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/traceback_3d.md
Name: traceback_3d

Overview:
- Traceback engine for the 3-sequence affine-gap alignment array.
- Consumes the predecessor-pointer memory written during the DP fill by the M/Ixy/Iyz/Ixz/Ix/Iy/Iz cells, starting from the final cell (LA,LB,LC) and a given end state.
- Walks back to the origin and streams one alignment column per step, in reverse order, to the downstream alignment formatter over a valid/ready interface.

Parameters:
- IDX_W, 8, width of each sequence index i/j/k (max length 2^IDX_W-1).
- PTR_W, 3, width of a stored state/pointer code.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle pulse; sampled only in IDLE
- len_a/len_b/len_c  input  IDX_W each  final cell indices, sampled on start
- start_state  input  PTR_W  end-state code, sampled on start
- ptr_rd_en  output  1  pointer memory read strobe
- ptr_addr  output  3*IDX_W+PTR_W  read address = {i,j,k,state}
- ptr_rd_data  input  PTR_W  predecessor state; valid exactly 1 cycle after ptr_rd_en
- col_valid  output  1  column available
- col_ready  input  1  downstream accepts column
- col_mask  output  3  consumption mask {A,B,C}; 1 = character, 0 = gap
- col_i/col_j/col_k  output  IDX_W each  character positions for this column
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse on completion (normal or error)
- err  output  1  sticky error flag; cleared on next accepted start

Behaviour:
- Reset: all outputs 0, FSM to IDLE, index/state registers 0.
- State codes and masks (package):
  - M=0 (111), Ixy=1 (110), Iyz=2 (011), Ixz=3 (101), Ix=4 (100), Iy=5 (010), Iz=6 (001), STOP=7 (invalid).
  - Every valid code consumes at least one index, so the walk always terminates.
- FSM states: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE:
  - On start, load i/j/k/s from the inputs and clear err.
  - If i=j=k=0, go to DONE without emitting a column.
  - Else if s=STOP, or any index is 0 where mask(s) has a 1, set err and go to DONE.
  - Else go to FETCH.
- FETCH: ptr_rd_en=1 for one cycle with ptr_addr={i,j,k,s}; next state WAIT.
- WAIT: capture ptr_rd_data into next_s; next state EMIT.
- EMIT:
  - col_valid=1, col_mask=mask(s), col_i/j/k=i/j/k; these hold stable until col_ready.
  - On handshake: i-=mask[2], j-=mask[1], k-=mask[0], s=next_s.
  - Then, evaluated on the new values:
    - all indices 0 → DONE (next_s is ignored at the origin);
    - s=STOP, or an index is 0 with its mask bit 1 → err=1, DONE;
    - otherwise → FETCH.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- Throughput: 3 cycles per column with col_ready held high. Latency from start to first col_valid is 3 cycles.
- start while busy is ignored. col_valid never depends combinationally on col_ready.
- Asynchronous reset mid-walk aborts immediately: no done pulse, and all outputs return to their reset values.

Optional Feature:
- Macro TB_COL_COUNT_EN.
- Defined:
  - Adds output col_count (IDX_W+2 bits), cleared on accepted start and incremented on each column handshake.
  - Value is held after DONE until the next start.
  - Adds a check: col_count exceeding len_a+len_b+len_c sets err and forces DONE.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package aln3_pkg holds:
  - the state code enum (M..STOP);
  - the mask lookup function state→3-bit mask;
  - the IDX_W/PTR_W defaults;
  - the ptr_addr packing function, shared with the fill-side pointer writer.
- One natural sub-module: tb_col_skid, a single-entry output register for the column interface so that col_* is registered.

Test Plan:
- Diagonal only: len=(3,3,3), start_state=M, memory returns M everywhere → 3 columns, mask 111, indices (3,3,3),(2,2,2),(1,1,1), then done, err=0.
- Mixed path: len=(2,1,1), start=M; ptr(2,1,1,M)=Ix, ptr(1,0,0,Ix)=Ix → columns 111@(2,1,1), 100@(1,0,0), then done.
- Zero-length start: len=(0,0,0) → no col_valid, done pulses 1 cycle after start, ptr_rd_en never asserted.
- Illegal pointer: len=(2,2,0), start=Ixy, ptr returns Iz → first column 110@(2,2,0), then err=1 and done with k=0 underflow detected; no further reads.
- Backpressure: hold col_ready=0 for 5 cycles during EMIT → col_* stable, no new ptr_rd_en; release → walk resumes with correct indices.
- Reset mid-walk: assert rst during WAIT → outputs immediately 0, busy=0; a subsequent start restarts cleanly. With TB_COL_COUNT_EN, col_count=0 after reset.
